// File: rtl/uart_wishbone_bridge_if.sv
// Bundles the byte-stream handshakes and the Wishbone classic bus of the UART bridge.
// The bridge uses "master"; the environment (UART, interconnect, bench) uses "slave".
interface uart_wishbone_bridge_if #(
    parameter int ADDR_WIDTH = 30
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [ADDR_WIDTH-1:0] wb_adr;
    logic [31:0]           wb_dat_w;
    logic [31:0]           wb_dat_r;
    logic [3:0]            wb_sel;
    logic                  wb_cyc;
    logic                  wb_stb;
    logic                  wb_we;
    logic                  wb_ack;
    logic                  wb_err;

    modport master (
        input  rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
        output rx_ready, tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wb_dat_r, wb_ack, wb_err,
        input  rx_ready, tx_data, tx_valid, wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we
    );
endinterface

// File: rtl/uart_wishbone_bridge.sv
// Host command engine: decodes UART byte frames into Wishbone single-word cycles
// and streams read data back out as bytes, MSB first.
module uart_wishbone_bridge #(
    parameter int ADDR_WIDTH     = 30,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_wishbone_bridge_if.master bus,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_ADDR,
        S_WDATA,
        S_WB,
        S_TX
    } state_e;

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q;
    logic                  rx_ready_q;
    logic                  tx_valid_q;
    logic                  cyc_q;
    logic                  we_q;
    logic                  is_read_q;
    logic [7:0]            count_q;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           wdat_q;
    logic [31:0]           tx_word_q;
    logic [TIMER_W-1:0]    timer_q;

    logic       rx_fire;
    logic       tx_fire;
    logic       wb_done;
    logic       in_frame;
    logic       timed_out;
    logic [7:0] count_d;

    assign rx_fire   = rx_ready_q & bus.rx_valid;
    assign tx_fire   = tx_valid_q & bus.tx_ready;
    assign wb_done   = cyc_q & (bus.wb_ack | bus.wb_err);
    assign count_d   = count_q - 8'd1;
    assign in_frame  = (state_q == S_LEN) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign timed_out = in_frame && !rx_fire && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_word_q[31:24];
    assign bus.wb_adr   = adr_q;
    assign bus.wb_dat_w = wdat_q;
    assign bus.wb_sel   = cyc_q ? 4'hF : 4'h0;
    assign bus.wb_cyc   = cyc_q;
    assign bus.wb_stb   = cyc_q;
    assign bus.wb_we    = we_q;
    assign busy         = (state_q != S_IDLE);

    // byte_cnt_q is 2 bits, so it wraps back to 0 after every 4-byte group on its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            is_read_q  <= 1'b0;
            count_q    <= '0;
            byte_cnt_q <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            tx_word_q  <= '0;
            timer_q    <= '0;
        end else begin
            if (in_frame && !rx_fire) begin
                timer_q <= timer_q + TIMER_W'(1);
            end else begin
                timer_q <= '0;
            end

            case (state_q)
                S_IDLE: begin
                    rx_ready_q <= 1'b1;
                    if (rx_fire && (bus.rx_data == 8'h01 || bus.rx_data == 8'h02)) begin
                        is_read_q <= (bus.rx_data == 8'h02);
                        state_q   <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (timed_out) begin
                        state_q <= S_IDLE;
                    end else if (rx_fire) begin
                        count_q    <= bus.rx_data;
                        byte_cnt_q <= '0;
                        state_q    <= S_ADDR;
                    end
                end

                // Shifting into adr_q keeps only the low ADDR_WIDTH bits of the 32-bit address.
                S_ADDR: begin
                    if (timed_out) begin
                        state_q <= S_IDLE;
                    end else if (rx_fire) begin
                        adr_q      <= {adr_q[ADDR_WIDTH-9:0], bus.rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (count_q == 8'd0) begin
                                state_q <= S_IDLE;
                            end else if (is_read_q) begin
                                state_q    <= S_WB;
                                cyc_q      <= 1'b1;
                                rx_ready_q <= 1'b0;
                            end else begin
                                state_q <= S_WDATA;
                            end
                        end
                    end
                end

                S_WDATA: begin
                    if (timed_out) begin
                        state_q <= S_IDLE;
                    end else if (rx_fire) begin
                        wdat_q     <= {wdat_q[23:0], bus.rx_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            state_q    <= S_WB;
                            cyc_q      <= 1'b1;
                            we_q       <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end
                    end
                end

                S_WB: begin
                    if (wb_done) begin
                        cyc_q <= 1'b0;
                        we_q  <= 1'b0;
                        adr_q <= adr_q + ADDR_WIDTH'(1);
                        if (!is_read_q) begin
                            count_q    <= count_d;
                            rx_ready_q <= 1'b1;
                            state_q    <= (count_d != 8'd0) ? S_WDATA : S_IDLE;
                        end else begin
                            tx_word_q  <= bus.wb_err ? 32'h0000_0000 : bus.wb_dat_r;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_TX;
                        end
                    end
                end

                // tx_data is the top byte of tx_word_q; it only shifts on an accepted byte.
                S_TX: begin
                    if (tx_fire) begin
                        tx_word_q  <= {tx_word_q[23:0], 8'h00};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            count_q    <= count_d;
                            if (count_d != 8'd0) begin
                                state_q <= S_WB;
                                cyc_q   <= 1'b1;
                            end else begin
                                state_q    <= S_IDLE;
                                rx_ready_q <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// Directed bench for uart_wishbone_bridge: a Wishbone responder and a UART tx sink
// run in the background while scenario tasks send host frames and check results.
module tb_uart_wishbone_bridge;

    localparam int AW = 30;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    uart_wishbone_bridge_if #(.ADDR_WIDTH(AW)) bif ();

    uart_wishbone_bridge #(
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    int   ack_delay = 2;
    logic resp_err  = 1'b0;
    int   tx_stall  = 0;

    logic [31:0] cyc_adr[$];
    logic [31:0] cyc_dat[$];
    logic        cyc_we[$];
    logic [3:0]  cyc_sel[$];
    logic [7:0]  tx_bytes[$];

    // Wishbone slave: acks ack_delay cycles after the strobe, logs each completed cycle,
    // and checks the bus is released (and read data appears) the cycle after the ack.
    initial begin : wb_responder
        int          wait_cnt;
        logic        ack_seen;
        logic        ack_read;
        logic [31:0] first_adr;
        logic [31:0] first_dat;
        wait_cnt   = 0;
        ack_seen   = 1'b0;
        ack_read   = 1'b0;
        first_adr  = '0;
        first_dat  = '0;
        bif.wb_ack = 1'b0;
        bif.wb_err = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bif.wb_ack = 1'b0;
            bif.wb_err = 1'b0;
            if (ack_seen) begin
                vectors++;
                if (bif.wb_cyc !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL cyc_release: got cyc=%b expected 0", bif.wb_cyc);
                end
                if (ack_read) begin
                    vectors++;
                    if (bif.tx_valid !== 1'b1) begin
                        miscompares++;
                        $display("[TB] FAIL ack_to_tx_valid: got %b expected 1", bif.tx_valid);
                    end
                end
                ack_seen = 1'b0;
            end
            if (bif.wb_cyc === 1'b1) begin
                if (wait_cnt == 0) begin
                    first_adr = 32'(bif.wb_adr);
                    first_dat = bif.wb_dat_w;
                end
                if (wait_cnt >= ack_delay) begin
                    vectors++;
                    if (32'(bif.wb_adr) !== first_adr || bif.wb_dat_w !== first_dat) begin
                        miscompares++;
                        $display("[TB] FAIL wb_hold: got adr=%h dat=%h expected adr=%h dat=%h",
                                 bif.wb_adr, bif.wb_dat_w, first_adr, first_dat);
                    end
                    cyc_adr.push_back(32'(bif.wb_adr));
                    cyc_dat.push_back(bif.wb_dat_w);
                    cyc_we.push_back(bif.wb_we);
                    cyc_sel.push_back(bif.wb_sel);
                    bif.wb_ack = 1'b1;
                    bif.wb_err = resp_err;
                    ack_seen   = 1'b1;
                    ack_read   = !bif.wb_we;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // UART tx sink: holds tx_ready low for tx_stall cycles per byte and checks tx_data stays put.
    initial begin : tx_sink
        int         stall_cnt;
        logic [7:0] held;
        stall_cnt    = 0;
        held         = '0;
        bif.tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bif.tx_ready = 1'b0;
            if (bif.tx_valid === 1'b1) begin
                if (stall_cnt > 0) begin
                    vectors++;
                    if (bif.tx_data !== held) begin
                        miscompares++;
                        $display("[TB] FAIL tx_hold: got %h expected %h", bif.tx_data, held);
                    end
                end
                if (stall_cnt >= tx_stall) begin
                    bif.tx_ready = 1'b1;
                    tx_bytes.push_back(bif.tx_data);
                    stall_cnt = 0;
                end else begin
                    held = bif.tx_data;
                    stall_cnt++;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    task automatic clear_logs();
        cyc_adr.delete();
        cyc_dat.delete();
        cyc_we.delete();
        cyc_sel.delete();
        tx_bytes.delete();
    endtask

    // Returns #1 after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n            = 0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        while (bif.rx_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL rx_accept_timeout: byte %h never accepted", b);
        end else begin
            @(posedge clk);
            #1;
        end
        bif.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(data[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL idle_timeout: busy still %b after %0d cycles", busy, limit);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++; if (bif.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rx_ready: got %b expected 0", bif.rx_ready); end
        vectors++; if (bif.wb_cyc !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cyc: got %b expected 0", bif.wb_cyc); end
        vectors++; if (bif.tx_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_valid: got %b expected 0", bif.tx_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (bif.wb_adr !== '0) begin miscompares++; $display("[TB] FAIL reset_adr: got %h expected 0", bif.wb_adr); end
        rst_n = 1'b1;
        vectors++; if (bif.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL release_rx_ready: got %b expected 0", bif.rx_ready); end
        @(posedge clk);
        #1;
        vectors++; if (bif.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL first_edge_rx_ready: got %b expected 1", bif.rx_ready); end
    endtask

    task automatic test_write_single();
        clear_logs();
        send_frame(128'({8'h01, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78}), 10);
        vectors++; if (bif.wb_stb !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_stb_latency: got %b expected 1", bif.wb_stb); end
        vectors++; if (bif.wb_we !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_we: got %b expected 1", bif.wb_we); end
        vectors++; if (bif.wb_sel !== 4'hF) begin miscompares++; $display("[TB] FAIL wr_sel: got %h expected f", bif.wb_sel); end
        vectors++; if (bif.wb_adr !== 30'h0400_0000) begin miscompares++; $display("[TB] FAIL wr_adr: got %h expected 04000000", bif.wb_adr); end
        vectors++; if (bif.wb_dat_w !== 32'h1234_5678) begin miscompares++; $display("[TB] FAIL wr_dat: got %h expected 12345678", bif.wb_dat_w); end
        vectors++; if (bif.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_rx_ready_wb: got %b expected 0", bif.rx_ready); end
        wait_idle(50);
        vectors++; if (cyc_adr.size() != 1) begin miscompares++; $display("[TB] FAIL wr_cycle_count: got %0d expected 1", cyc_adr.size()); end
        if (cyc_adr.size() >= 1) begin
            vectors++;
            if (cyc_adr[0] !== 32'h0400_0000 || cyc_dat[0] !== 32'h1234_5678 || cyc_we[0] !== 1'b1 || cyc_sel[0] !== 4'hF) begin
                miscompares++;
                $display("[TB] FAIL wr_logged: got adr=%h dat=%h we=%b sel=%h expected 04000000 12345678 1 f",
                         cyc_adr[0], cyc_dat[0], cyc_we[0], cyc_sel[0]);
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_read_single();
        logic [31:0] exp_w;
        exp_w = 32'hFACE_CA8C;
        clear_logs();
        bif.wb_dat_r = exp_w;
        send_frame(128'({8'h02, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00}), 6);
        vectors++; if (bif.wb_stb !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_stb: got %b expected 1", bif.wb_stb); end
        vectors++; if (bif.wb_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_we: got %b expected 0", bif.wb_we); end
        wait_idle(100);
        vectors++; if (tx_bytes.size() != 4) begin miscompares++; $display("[TB] FAIL rd_tx_count: got %0d expected 4", tx_bytes.size()); end
        for (int i = 0; i < 4 && i < tx_bytes.size(); i++) begin
            vectors++;
            if (tx_bytes[i] !== exp_w[31-8*i -: 8]) begin
                miscompares++;
                $display("[TB] FAIL rd_tx_byte%0d: got %h expected %h", i, tx_bytes[i], exp_w[31-8*i -: 8]);
            end
        end
        vectors++; if (cyc_we.size() != 1) begin miscompares++; $display("[TB] FAIL rd_cycle_count: got %0d expected 1", cyc_we.size()); end
        if (cyc_we.size() >= 1) begin
            vectors++;
            if (cyc_we[0] !== 1'b0 || cyc_adr[0] !== 32'h0400_0000) begin
                miscompares++;
                $display("[TB] FAIL rd_logged: got we=%b adr=%h expected 0 04000000", cyc_we[0], cyc_adr[0]);
            end
        end
    endtask

    task automatic test_multi_write();
        logic [31:0] exp_adr[4];
        logic [31:0] exp_dat[4];
        exp_adr = '{32'h0000_2400, 32'h0000_2401, 32'h3FFF_FFFF, 32'h0000_0000};
        exp_dat = '{32'hAABB_CCDD, 32'h1122_3344, 32'h0102_0304, 32'h0506_0708};
        clear_logs();
        send_frame(128'({8'h01, 8'h02, 8'h00, 8'h00, 8'h24, 8'h00,
                         8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44}), 14);
        wait_idle(100);
        // Address FFFFFFFF truncates to 3FFFFFFF; the second word wraps to 0.
        send_frame(128'({8'h01, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}), 14);
        wait_idle(100);
        vectors++; if (cyc_adr.size() != 4) begin miscompares++; $display("[TB] FAIL mw_cycle_count: got %0d expected 4", cyc_adr.size()); end
        for (int i = 0; i < 4 && i < cyc_adr.size(); i++) begin
            vectors++;
            if (cyc_adr[i] !== exp_adr[i] || cyc_dat[i] !== exp_dat[i] || cyc_we[i] !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL mw_word%0d: got adr=%h dat=%h we=%b expected adr=%h dat=%h we=1",
                         i, cyc_adr[i], cyc_dat[i], cyc_we[i], exp_adr[i], exp_dat[i]);
            end
        end
    endtask

    task automatic test_tx_stall();
        logic [31:0] exp_w;
        logic        rx_seen;
        logic        early_cyc;
        int          n;
        exp_w     = 32'h0BAD_F00D;
        rx_seen   = 1'b0;
        early_cyc = 1'b0;
        clear_logs();
        bif.wb_dat_r = exp_w;
        tx_stall     = 5;
        send_frame(128'({8'h02, 8'h02, 8'h00, 8'h00, 8'h90, 8'h10}), 6);
        n = 0;
        while (busy === 1'b1 && n < 500) begin
            if (bif.rx_ready !== 1'b0) rx_seen = 1'b1;
            if (bif.wb_cyc === 1'b1 && (tx_bytes.size() % 4) != 0) early_cyc = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        tx_stall = 0;
        vectors++; if (n >= 500) begin miscompares++; $display("[TB] FAIL stall_idle_timeout: busy after %0d cycles", n); end
        vectors++; if (rx_seen !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_rx_ready: got rx_ready high expected low"); end
        vectors++; if (early_cyc !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_early_cycle: got bus cycle mid-word expected none"); end
        vectors++; if (tx_bytes.size() != 8) begin miscompares++; $display("[TB] FAIL stall_tx_count: got %0d expected 8", tx_bytes.size()); end
        for (int i = 0; i < 8 && i < tx_bytes.size(); i++) begin
            vectors++;
            if (tx_bytes[i] !== exp_w[31-8*(i%4) -: 8]) begin
                miscompares++;
                $display("[TB] FAIL stall_tx_byte%0d: got %h expected %h", i, tx_bytes[i], exp_w[31-8*(i%4) -: 8]);
            end
        end
        vectors++;
        if (cyc_adr.size() != 2 || (cyc_adr.size() == 2 && (cyc_adr[0] !== 32'h9010 || cyc_adr[1] !== 32'h9011))) begin
            miscompares++;
            $display("[TB] FAIL stall_cycles: got %0d cycles expected 2 at 9010/9011", cyc_adr.size());
        end
    endtask

    task automatic test_ignore_and_len0();
        clear_logs();
        send_byte(8'h55);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL junk_busy: got %b expected 0", busy); end
        send_frame(128'({8'h01, 8'h00, 8'h00, 8'h00, 8'h90, 8'h00}), 6);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL len0_busy: got %b expected 0", busy); end
        vectors++; if (bif.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL len0_rx_ready: got %b expected 1", bif.rx_ready); end
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (cyc_adr.size() != 0) begin miscompares++; $display("[TB] FAIL len0_cycles: got %0d expected 0", cyc_adr.size()); end
    endtask

    task automatic test_timeout();
        clear_logs();
        send_frame(128'({8'h01, 8'h01, 8'h00, 8'h00}), 4);
        repeat (8) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL to_early_abort: got busy=%b expected 1", busy); end
        repeat (30) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL to_abort: got busy=%b expected 0", busy); end
        vectors++; if (bif.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL to_rx_ready: got %b expected 1", bif.rx_ready); end
        vectors++; if (cyc_adr.size() != 0) begin miscompares++; $display("[TB] FAIL to_no_cycle: got %0d expected 0", cyc_adr.size()); end
        send_frame(128'({8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF}), 10);
        wait_idle(50);
        vectors++;
        if (cyc_adr.size() != 1 || (cyc_adr.size() == 1 && (cyc_adr[0] !== 32'h5 || cyc_dat[0] !== 32'hDEAD_BEEF))) begin
            miscompares++;
            $display("[TB] FAIL to_recover: got %0d cycles expected 1 at 00000005 with deadbeef", cyc_adr.size());
        end
    endtask

    task automatic test_reset_mid_wb();
        clear_logs();
        ack_delay = 1000;
        send_frame(128'({8'h02, 8'h01, 8'h00, 8'h00, 8'h90, 8'h00}), 6);
        vectors++; if (bif.wb_cyc !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_pre_cyc: got %b expected 1", bif.wb_cyc); end
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++; if (bif.wb_cyc !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_cyc: got %b expected 0", bif.wb_cyc); end
        vectors++; if (bif.wb_stb !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_stb: got %b expected 0", bif.wb_stb); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy); end
        vectors++; if (bif.rx_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_async_rx_ready: got %b expected 0", bif.rx_ready); end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (bif.rx_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_recover_rx_ready: got %b expected 1", bif.rx_ready); end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if (tx_bytes.size() != 0) begin miscompares++; $display("[TB] FAIL rst_no_tx: got %0d bytes expected 0", tx_bytes.size()); end
        vectors++; if (cyc_adr.size() != 0) begin miscompares++; $display("[TB] FAIL rst_no_ack: got %0d cycles expected 0", cyc_adr.size()); end
        ack_delay = 2;
    endtask

    task automatic test_err_read();
        clear_logs();
        resp_err     = 1'b1;
        bif.wb_dat_r = 32'hFACE_CA8C;
        send_frame(128'({8'h02, 8'h01, 8'h00, 8'h00, 8'h90, 8'h04}), 6);
        wait_idle(100);
        resp_err = 1'b0;
        vectors++; if (tx_bytes.size() != 4) begin miscompares++; $display("[TB] FAIL err_tx_count: got %0d expected 4", tx_bytes.size()); end
        for (int i = 0; i < 4 && i < tx_bytes.size(); i++) begin
            vectors++;
            if (tx_bytes[i] !== 8'h00) begin
                miscompares++;
                $display("[TB] FAIL err_tx_byte%0d: got %h expected 00", i, tx_bytes[i]);
            end
        end
        vectors++;
        if (cyc_adr.size() != 1 || (cyc_adr.size() == 1 && cyc_adr[0] !== 32'h9004)) begin
            miscompares++;
            $display("[TB] FAIL err_cycle: got %0d cycles expected 1 at 00009004", cyc_adr.size());
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        bif.rx_data  = 8'h00;
        bif.rx_valid = 1'b0;
        bif.wb_dat_r = 32'h0;
        test_reset();
        test_write_single();
        test_read_single();
        test_multi_write();
        test_tx_stall();
        test_ignore_and_len0();
        test_timeout();
        test_reset_mid_wb();
        test_err_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_wishbone_bridge.md
Name: uart_wishbone_bridge

Overview:
- Byte-stream protocol engine between the UART receiver/transmitter and the SoC Wishbone interconnect.
- Decodes host command frames (write/read, word count, 32-bit word address), issues Wishbone classic single-word cycles, and returns read data as bytes.
- This is the host control path for the DFII registers (0x9000 region) and the DRAM window (0x10000000 region).

Parameters:
- ADDR_WIDTH, 30, Wishbone word-address width; the received 32-bit address is truncated to its low ADDR_WIDTH bits.
- TIMEOUT_CYCLES, 1000000, idle-gap limit between bytes of one frame before the frame is aborted (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx_data
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- wb_adr  out  ADDR_WIDTH  Wishbone word address
- wb_dat_w  out  32  write data
- wb_dat_r  in  32  read data
- wb_sel  out  4  byte select, always 0xF during a cycle
- wb_cyc  out  1  cycle
- wb_stb  out  1  strobe
- wb_we  out  1  write enable
- wb_ack  in  1  acknowledge
- wb_err  in  1  error, treated as termination
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n low): all outputs go to 0 immediately; state = IDLE; counters cleared. wb_cyc drops even mid-cycle. rx_ready returns to 1 on the first clk edge after rst_n rises.
- Frame format: CMD, LEN, A[31:24], A[23:16], A[15:8], A[7:0], then payload.
  - CMD 0x01 = write; the payload is LEN words, 4 bytes each, MSB first.
  - CMD 0x02 = read; the bridge returns LEN words, 4 bytes each, MSB first.
  - LEN is an 8-bit word count. LEN = 0 means the frame ends after the address, with no bus cycle.
- A byte is accepted on a clk edge with rx_valid & rx_ready.
- States:
  - IDLE (rx_ready=1): accepting 0x01 or 0x02 -> LEN. Any other byte is discarded and the state stays IDLE.
  - LEN (rx_ready=1): latch count -> ADDR.
  - ADDR (rx_ready=1): 4 bytes. After the 4th byte: if count = 0 -> IDLE; write -> WDATA; read -> WB.
  - WDATA (rx_ready=1): shift in 4 bytes. The cycle after the 4th byte is accepted, enter WB with cyc=stb=we=1.
  - WB (rx_ready=0): cyc/stb/adr/dat_w/we held stable until wb_ack|wb_err is sampled high. On that edge, cyc=stb=we=0 and adr increments by 1, wrapping modulo 2^ADDR_WIDTH.
    - Write: count decrements; if the remaining count is nonzero -> WDATA, else -> IDLE.
    - Read: latch wb_dat_r, or 0x00000000 if wb_err -> TX.
  - TX (rx_ready=0): tx_valid=1; tx_data = byte 3, then 2, 1, 0 of the latched word. A byte advances on tx_valid & tx_ready. tx_data must be stable while tx_valid & !tx_ready. After the 4th byte: count decrements; if nonzero -> WB, else -> IDLE.
- Minimum latency: 1 cycle from the last write-data byte to wb_stb; 1 cycle from ack to tx_valid.
- If ack and err are both high, treat as err.
- Inter-byte timeout:
  - A counter runs in LEN, ADDR and WDATA and clears on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, go to IDLE, discard partial data, and issue no bus cycle. Words already written in this frame remain written.
  - No timeout applies in WB or TX.
- Bytes presented while rx_ready=0 are not consumed. The upstream holds them.

Test Plan:
- Frame 01 01 04 00 00 00 12 34 56 78, wb_ack 2 cycles after stb -> one cycle with adr=0x04000000, dat_w=0x12345678, we=1, sel=0xF; then IDLE and busy=0.
- Frame 02 01 04 00 00 00, wb_dat_r=0xFACECA8C on ack -> tx bytes FA, CE, CA, 8C in order; we=0 throughout.
- Frame 01 02 00 00 24 00 + 8 data bytes -> two writes at adr 0x2400 then 0x2401; adr=0x3FFFFFFF with LEN=2 -> second write at 0x00000000.
- Read with tx_ready low for 5 cycles per byte -> tx_data held stable; no second bus cycle before all 4 bytes are sent; rx_ready=0 throughout.
- Bytes 0x55 then 01 00 00 00 90 00 -> 0x55 ignored, LEN=0 frame produces no cycle; next, 01 01 with a gap of TIMEOUT_CYCLES (set to 16) -> return to IDLE, no cycle.
- rst_n pulsed low during WB of a read; wb_err path -> cyc drops asynchronously, no tx byte emitted; a read terminated with err returns 00 00 00 00.
